// File: rtl/result_display_driver.sv
// Seven-segment driver for the game value bus: steady digits, blinking result
// glyphs, and a saturating streak of consecutive correct answers shown on dp.
module result_display_driver #(
    parameter int unsigned BLINK_HALF = 5_000_000,
    parameter int unsigned STREAK_MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] streak
);

    typedef enum logic {
        PH_ON,
        PH_OFF
    } phase_t;

    localparam logic [23:0] HALF_LAST  = 24'(BLINK_HALF - 1);
    localparam logic [3:0]  STREAK_SAT = 4'(STREAK_MAX);
    localparam logic [3:0]  CODE_OK    = 4'd10;
    localparam logic [3:0]  CODE_BAD   = 4'd11;

    logic [3:0]  value_q,     value_d;
    logic [6:0]  seg_q,       seg_d;
    logic        dp_q,        dp_d;
    logic [3:0]  streak_q,    streak_d;
    logic [23:0] blink_cnt_q, blink_cnt_d;
    phase_t      phase_q,     phase_d;

    logic entry;
    logic is_result;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            4'd10:   g = 7'h5C;
            4'd11:   g = 7'h79;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    always_comb begin
        value_d     = value;
        blink_cnt_d = '0;
        phase_d     = PH_ON;
        streak_d    = streak_q;

        entry     = (value != value_q);
        is_result = (value == CODE_OK) || (value == CODE_BAD);

        // An entry edge restarts the blink, so only a held result code advances it.
        if (is_result && !entry) begin
            if (blink_cnt_q == HALF_LAST) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                blink_cnt_d = blink_cnt_q + 24'd1;
                phase_d     = phase_q;
            end
        end

        seg_d = (phase_d == PH_ON) ? glyph(value) : '0;

        if (entry) begin
            if (value == CODE_OK) begin
                streak_d = (streak_q >= STREAK_SAT) ? STREAK_SAT : streak_q + 4'd1;
            end else if (value == CODE_BAD) begin
                streak_d = '0;
            end
        end

        dp_d = (streak_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q     <= '1;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            streak_q    <= '0;
            blink_cnt_q <= '0;
            phase_q     <= PH_ON;
        end else begin
            value_q     <= value_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            streak_q    <= streak_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign seg    = seg_q;
    assign dp     = dp_q;
    assign streak = streak_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Scoreboard bench for result_display_driver: a cycle-count reference model
// predicts seg/dp/streak per sampled value; a monitor compares after each edge.
module tb_result_display_driver;

    localparam int unsigned BH = 4;
    localparam int unsigned SM = 9;

    logic       clk;
    logic       reset;
    logic [3:0] value;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] streak;

    result_display_driver #(
        .BLINK_HALF (BH),
        .STREAK_MAX (SM)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .value  (value),
        .seg    (seg),
        .dp     (dp),
        .streak (streak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h5C, 7'h79, 7'h00, 7'h00, 7'h00, 7'h00};

    // Reference model: previous code, cycles since entering a result code, streak.
    int m_prev;
    int m_k;
    int m_streak;

    task automatic model_reset();
        m_prev   = 15;
        m_k      = 0;
        m_streak = 0;
    endtask

    task automatic drive(input int v);
        bit   entry;
        int   s;
        logic [6:0] eseg;
        value = 4'(v);
        entry = (v != m_prev);
        if (v == 10 || v == 11) begin
            m_k  = entry ? 0 : m_k + 1;
            eseg = (((m_k / BH) % 2) == 0) ? glyph_tab[v] : 7'h00;
        end else begin
            m_k  = 0;
            eseg = glyph_tab[v];
        end
        if (entry && v == 10) m_streak = (m_streak + 1 > SM) ? SM : m_streak + 1;
        if (entry && v == 11) m_streak = 0;
        m_prev = v;
        s = m_streak;
        exp_q.push_back({eseg, (s != 0), 4'(s)});
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (seg !== 7'h00 || dp !== 1'b0 || streak !== 4'h0) begin
            errors++;
            $display("FAIL %s: seg=%h dp=%b streak=%0d, required seg=00 dp=0 streak=0",
                     tag, seg, dp, streak);
        end
    endtask

    // Monitor: one expected entry per sampled edge while out of reset.
    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({seg, dp, streak} !== e) begin
                    errors++;
                    $display("FAIL out @%0t: seg=%h dp=%b streak=%0d, required seg=%h dp=%b streak=%0d",
                             $time, seg, dp, streak, e[11:5], e[4], e[3:0]);
                end
            end
        end
    end

    initial begin
        int v;
        int len;
        int waited;
        reset = 1'b1;
        value = 4'd7;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset_initial");
        reset = 1'b0;

        repeat (20) drive(7);

        drive(3);
        repeat (16) drive(10);

        for (int i = 0; i < 10; i++) begin
            drive(5);
            drive(10);
        end
        repeat (10) drive(11);

        repeat (6) drive(10);
        repeat (8) drive(11);

        repeat (3) drive(13);
        drive(10);
        repeat (5) drive(11);

        value = 4'd11;
        reset = 1'b1;
        #1;
        check_reset_state("reset_mid_blink");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(11);
        repeat (3) drive(10);

        for (int seg_i = 0; seg_i < 250; seg_i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                #1;
                check_reset_state("reset_random");
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
            if ($urandom_range(0, 9) < 5) v = 10 + int'($urandom_range(0, 1));
            else v = int'($urandom_range(0, 15));
            len = int'($urandom_range(1, 12));
            repeat (len) drive(v);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected outputs left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
